// File: rtl/axil_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// axil_cfg_arbiter
//
// Two-requester AXI4-Lite master for the pl_reg0 configuration register
// slave (4 x 32-bit registers). Requesters issue single-word read/write
// commands. The block grants them round-robin and runs exactly one AXI4-Lite
// transaction at a time. It returns the read data and response code to the
// requester that issued the command.
//
// Ports
//   ACLK, ARESETN       clock, asynchronous active-low reset
//   req_valid[1:0]      per-requester command valid
//   req_ready[1:0]      one-cycle accept pulse (only in IDLE, never both bits)
//   req_write[1:0]      per-requester 1=write, 0=read
//   req_addr, req_wdata per-requester address / write data; slice r = requester r
//   rsp_valid[1:0]      one-cycle response pulse to the granted requester
//   rsp_rdata, rsp_resp shared read data / response code, held between pulses
//   m_axi_*             AXI4-Lite master port (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axil_cfg_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_write,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t                  state_reg,      state_next;
    logic                    last_grant_reg, last_grant_next;
    logic                    grant_reg,      grant_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,       addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg,      wdata_next;
    logic                    awvalid_reg,    awvalid_next;
    logic                    wvalid_reg,     wvalid_next;
    logic                    bready_reg,     bready_next;
    logic                    arvalid_reg,    arvalid_next;
    logic                    rready_reg,     rready_next;
    logic [1:0]              rsp_valid_reg,  rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg,  rsp_rdata_next;
    logic [1:0]              rsp_resp_reg,   rsp_resp_next;

    logic [1:0]              req_ready_comb;
    logic                    grant_sel;

    // Per-requester views of the packed command buses, word-aligned here so
    // the captured address never carries byte-offset bits.
    logic [ADDR_WIDTH-1:0]   addr_slice  [2];
    logic [DATA_WIDTH-1:0]   wdata_slice [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign addr_slice[gi]  = {req_addr[gi*ADDR_WIDTH+2 +: ADDR_WIDTH-2], 2'b00};
            assign wdata_slice[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: a lone requester wins outright; on contention the
    // requester that was not served last time wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_sel = ~last_grant_reg;
        end else begin
            grant_sel = ~req_valid[0];
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        awvalid_next    = awvalid_reg;
        wvalid_next     = wvalid_reg;
        bready_next     = bready_reg;
        arvalid_next    = arvalid_reg;
        rready_next     = rready_reg;
        rsp_valid_next  = 2'b00;
        rsp_rdata_next  = rsp_rdata_reg;
        rsp_resp_next   = rsp_resp_reg;
        req_ready_comb  = 2'b00;

        case (state_reg)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready_comb  = grant_sel ? 2'b10 : 2'b01;
                    grant_next      = grant_sel;
                    last_grant_next = grant_sel;
                    addr_next       = addr_slice[grant_sel];
                    wdata_next      = wdata_slice[grant_sel];
                    if (req_write[grant_sel]) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_ADDR;
                    end
                end
            end

            WR: begin
                // AW and W complete independently; each valid falls only on
                // its own handshake, and B is awaited once both are done.
                awvalid_next = awvalid_reg & ~m_axi_awready;
                wvalid_next  = wvalid_reg  & ~m_axi_wready;
                if (!awvalid_next && !wvalid_next) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (m_axi_bvalid && bready_reg) begin
                    rsp_rdata_next = '0;
                    rsp_resp_next  = m_axi_bresp;
                    bready_next    = 1'b0;
                    rsp_valid_next = grant_reg ? 2'b10 : 2'b01;
                    state_next     = RSP;
                end
            end

            RD_ADDR: begin
                if (m_axi_arready && arvalid_reg) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (m_axi_rvalid && rready_reg) begin
                    rsp_rdata_next = m_axi_rdata;
                    rsp_resp_next  = m_axi_rresp;
                    rready_next    = 1'b0;
                    rsp_valid_next = grant_reg ? 2'b10 : 2'b01;
                    state_next     = RSP;
                end
            end

            RSP: begin
                // rsp_valid_reg is high during this single cycle.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            rsp_valid_reg  <= 2'b00;
            rsp_rdata_reg  <= '0;
            rsp_resp_reg   <= 2'b00;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            awvalid_reg    <= awvalid_next;
            wvalid_reg     <= wvalid_next;
            bready_reg     <= bready_next;
            arvalid_reg    <= arvalid_next;
            rready_reg     <= rready_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_resp_reg   <= rsp_resp_next;
        end
    end

    // The accept pulse is combinational so capture happens in the same cycle;
    // it is forced low while reset is held so no command is acknowledged then.
    assign req_ready     = ARESETN ? req_ready_comb : 2'b00;

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;

    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_axil_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_cfg_arbiter
//
// Scoreboard bench for axil_cfg_arbiter. Two requester drivers feed command
// queues into the DUT. A behavioural AXI4-Lite slave with programmable ready
// and read delays sits on the master port. At every accept pulse the monitor
// runs a reference model: a round-robin pick, a 4-word register array and a
// latency formula. It pushes the expected response into a queue. Each
// rsp_valid pulse pops that queue and is compared against it.
// ---------------------------------------------------------------------------
module tb_axil_cfg_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    // Requester-side stimulus, one set of variables per driver process.
    logic        rv0 = 1'b0, rv1 = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    logic [3:0]  ad0 = '0,   ad1 = '0;
    logic [31:0] wd0 = '0,   wd1 = '0;

    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_resp;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata;

    assign req_valid = {rv1, rv0};
    assign req_write = {wr1, wr0};
    assign req_addr  = {ad1, ad0};
    assign req_wdata = {wd1, wd0};

    logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    axil_cfg_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          cyc;
        int          lat;
    } exp_t;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb_q[$];
    int   glog[$];

    int   cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave behaviour knobs (environment settings read by the model too).
    int   aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    bit   err_mode = 1'b0;

    // ---------------- AXI4-Lite slave model ----------------
    logic [31:0] smem [4];
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, r_pend;
    logic [3:0]  aw_a, r_a;
    logic [31:0] w_d;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, viol_aw = 0, viol_w = 0, viol_ar = 0;
    logic        aw_hs, w_hs, ar_hs;
    logic [1:0]  w_idx;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
    assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_delay);
    assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid  && m_axi_wready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign w_idx = aw_hs ? m_axi_awaddr[3:2] : aw_a[3:2];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_a <= '0; r_a <= '0; w_d <= '0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
            for (int i = 0; i < 4; i++) smem[i] <= '0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !aw_hs) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid  && !w_hs)  ? w_cnt + 1  : 0;
            ar_cnt <= (m_axi_arvalid && !ar_hs) ? ar_cnt + 1 : 0;
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_a      <= m_axi_awaddr;
                aw_hs_cnt <= aw_hs_cnt + 1;
                if (m_axi_awaddr[1:0] != 2'b00 || m_axi_awprot != 3'b000) viol_aw <= viol_aw + 1;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_d      <= m_axi_wdata;
                w_hs_cnt <= w_hs_cnt + 1;
                if (m_axi_wstrb != 4'hF) viol_w <= viol_w + 1;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                smem[w_idx]  <= w_hs ? m_axi_wdata : w_d;
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= (err_mode && w_idx == 2'd3) ? 2'b11 : 2'b00;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (ar_hs) begin
                if (m_axi_araddr[1:0] != 2'b00 || m_axi_arprot != 3'b000) viol_ar <= viol_ar + 1;
                if (r_delay == 0) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= smem[m_axi_araddr[3:2]];
                    m_axi_rresp  <= (err_mode && m_axi_araddr[3:2] == 2'd3) ? 2'b10 : 2'b00;
                end else begin
                    r_pend <= 1'b1;
                    r_cnt  <= 1;
                    r_a    <= m_axi_araddr;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= smem[r_a[3:2]];
                    m_axi_rresp  <= (err_mode && r_a[3:2] == 2'd3) ? 2'b10 : 2'b00;
                    r_pend       <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // ---------------- requester drivers ----------------
    int acc0 = 0, acc1 = 0;

    initial begin
        int   seen;
        cmd_t c;
        seen = 0;
        forever begin
            @(posedge ACLK); #1;
            if (acc0 != seen) begin seen = acc0; rv0 = 1'b0; end
            if (!ARESETN) rv0 = 1'b0;
            else if (!rv0 && q0.size() > 0) begin
                c = q0.pop_front();
                wr0 = c.wr; ad0 = c.addr; wd0 = c.data; rv0 = 1'b1;
            end
        end
    end

    initial begin
        int   seen;
        cmd_t c;
        seen = 0;
        forever begin
            @(posedge ACLK); #1;
            if (acc1 != seen) begin seen = acc1; rv1 = 1'b0; end
            if (!ARESETN) rv1 = 1'b0;
            else if (!rv1 && q1.size() > 0) begin
                c = q1.pop_front();
                wr1 = c.wr; ad1 = c.addr; wd1 = c.data; rv1 = 1'b1;
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    bit          model_last = 1'b1;
    logic [31:0] model_mem [4];
    int          aw_hi = 0, w_hi = 0, b_hs = 0;

    always @(negedge ACLK) begin
        exp_t        e;
        int          g;
        logic [1:0]  exp_onehot;
        logic [1:0]  idx;
        bit          cwr;
        logic [3:0]  caddr;
        logic [31:0] cdata;
        if (!ARESETN) begin
            sb_q.delete();
            glog.delete();
            model_last = 1'b1;
            for (int i = 0; i < 4; i++) model_mem[i] = '0;
        end else begin
            if (rsp_valid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("rsp valid=%b rdata=%08h resp=%0d latency=%0d", rsp_valid, rsp_rdata, rsp_resp, cyc - e.cyc);
                    chk("rsp_who",     64'(rsp_valid), 64'(e.who));
                    chk("rsp_rdata",   64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_resp",    64'(rsp_resp),  64'(e.resp));
                    chk("rsp_latency", 64'(cyc - e.cyc), 64'(e.lat));
                end
            end
            if (req_ready != 2'b00) begin
                if (req_valid == 2'b11) g = model_last ? 0 : 1;
                else                    g = req_valid[0] ? 0 : 1;
                exp_onehot = (req_valid == 2'b00) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
                chk("grant", 64'(req_ready), 64'(exp_onehot));
                chk("grant_while_busy", 64'(sb_q.size()), 64'd0);
                if (req_valid != 2'b00) begin
                    model_last = (g == 1);
                    glog.push_back(g);
                    cwr   = (g == 1) ? wr1 : wr0;
                    caddr = (g == 1) ? ad1 : ad0;
                    cdata = (g == 1) ? wd1 : wd0;
                    idx   = caddr[3:2];
                    e.who = exp_onehot;
                    e.cyc = cyc;
                    if (cwr) begin
                        e.rdata = '0;
                        e.resp  = (err_mode && idx == 2'd3) ? 2'b11 : 2'b00;
                        e.lat   = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay);
                        model_mem[idx] = cdata;
                    end else begin
                        e.rdata = model_mem[idx];
                        e.resp  = (err_mode && idx == 2'd3) ? 2'b10 : 2'b00;
                        e.lat   = 3 + ar_delay;
                    end
                    sb_q.push_back(e);
                    $display("grant req%0d %s addr=%h wdata=%08h", g, cwr ? "WR" : "RD", caddr, cdata);
                end
                if (req_ready[0]) acc0++;
                if (req_ready[1]) acc1++;
                aw_hi = 0; w_hi = 0; b_hs = 0;
            end
            if (m_axi_awvalid) aw_hi++;
            if (m_axi_wvalid)  w_hi++;
            if (m_axi_bvalid && m_axi_bready) b_hs++;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || rv0 || rv1 || sb_q.size() > 0) && n < budget) begin
            @(posedge ACLK);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'(n), 64'(budget - 1));
        repeat (2) @(posedge ACLK);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valids"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                   m_axi_rready, rsp_valid, req_ready}), 64'd0);
        chk({tag, "_rsp"},    64'({rsp_rdata, rsp_resp}), 64'd0);
        chk({tag, "_addr"},   64'({m_axi_awaddr, m_axi_araddr}), 64'd0);
        chk({tag, "_wdata"},  64'(m_axi_wdata), 64'd0);
    endtask

    function automatic cmd_t mk(input bit wr, input logic [3:0] addr, input logic [31:0] data);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.data = data;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int exp_seq [8];
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};

        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #2;
        chk_outputs_zero("reset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        // Single write from requester 0 with a zero-wait slave.
        q0.push_back(mk(1'b1, 4'h0, 32'h0000_0001));
        wait_idle(100);

        // Requester 1 fills all four registers then reads them back.
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, 4'(i * 4), 32'(i + 1)));
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 4'(i * 4), 32'h0));
        wait_idle(300);

        // Both requesters hold req_valid continuously: strict alternation.
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 4'h0, 32'h0));
            q1.push_back(mk(1'b0, 4'h4, 32'h0));
        end
        wait_idle(300);
        chk("rr_grant_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_sequence", 64'(glog[i]), 64'(exp_seq[i]));

        // awready held off for 3 cycles while wready is immediate.
        aw_delay = 3;
        q0.push_back(mk(1'b1, 4'h8, 32'hA5A5_0003));
        wait_idle(100);
        chk("aw_valid_cycles", 64'(aw_hi), 64'd4);
        chk("w_valid_cycles",  64'(w_hi),  64'd1);
        chk("b_handshakes",    64'(b_hs),  64'd1);
        aw_delay = 0;

        // SLVERR on a read of 0xC is passed through with the slave data.
        err_mode = 1'b1;
        q0.push_back(mk(1'b0, 4'hC, 32'h0));
        wait_idle(100);
        err_mode = 1'b0;

        // Randomized traffic, slave delays and error injection.
        for (int it = 0; it < 16; it++) begin
            aw_delay = int'($urandom_range(0, 3));
            w_delay  = int'($urandom_range(0, 3));
            ar_delay = int'($urandom_range(0, 3));
            err_mode = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 1)
                    q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
                else
                    q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
            end
            wait_idle(600);
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0; err_mode = 1'b0;

        // Reset while waiting in RD_DATA: everything drops, no response.
        r_delay = 20;
        q1.push_back(mk(1'b0, 4'h4, 32'h0));
        n = 0;
        while (!m_axi_rready && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("reached_rd_data", 64'(n < 100), 64'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (3) @(negedge ACLK);
        #2;
        ARESETN = 1'b1;
        r_delay = 0;
        repeat (5) @(posedge ACLK);

        // First contended request after release goes to requester 0.
        q0.push_back(mk(1'b0, 4'h0, 32'h0));
        q1.push_back(mk(1'b0, 4'h4, 32'h0));
        wait_idle(100);
        chk("post_reset_grants", 64'(glog.size()), 64'd2);
        if (glog.size() > 0) chk("post_reset_first_grant", 64'(glog[0]), 64'd0);

        chk("aw_protocol",   64'(viol_aw), 64'd0);
        chk("w_protocol",    64'(viol_w),  64'd0);
        chk("ar_protocol",   64'(viol_ar), 64'd0);
        chk("aw_w_pairing",  64'(aw_hs_cnt), 64'(w_hs_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
